clk_branch_sequencer: RTL and testbench

Clock-tree branch enable sequencer for the 7-track 5V0 library. It drives the enable pins of NBR integrated clock gates, each feeding a clkbuf-driven clock branch. It switches branches on and off one at a time, with a fixed stagger, to bound supply inrush and di/dt. Requesters ask for a branch with a level request and receive a delayed acknowledge once the branch clock has settled.

---
 rtl/clk_seq_pkg.sv | 29 ++
 rtl/clk_seq_dly.sv | 34 +++
 rtl/clk_branch_sequencer.sv | 86 ++++++++
 tb/tb_clk_branch_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/clk_seq_pkg.sv
// Shared types, defaults and the round-robin search used by the clock-branch
// enable sequencer.
package clk_seq_pkg;

    localparam int NBR_DEF     = 4;
    localparam int STAGGER_DEF = 8;
    localparam int SETTLE_DEF  = 2;
    localparam int MAX_NBR     = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } seq_state_e;

    // Returns the first set bit found scanning start, start+1, ... modulo n.
    // The scan runs backwards so the earliest hit is the one that sticks.
    // Falls back to start when vec is empty; callers only use it when vec != 0.
    function automatic int rr_first(input logic [MAX_NBR-1:0] vec,
                                    input int n,
                                    input int start);
        int pos;
        rr_first = start;
        for (int k = n - 1; k >= 0; k--) begin
            pos = (start + k) % n;
            if (vec[pos[3:0]]) rr_first = pos;
        end
    endfunction

endpackage

// File: rtl/clk_seq_dly.sv
// SETTLE-deep, synchronously reset 1-bit shift register; turns an enable into
// its acknowledge once the gated branch clock has had time to settle.
module clk_seq_dly
    import clk_seq_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SETTLE-1:0] stage;

    // NOTE: every stage is reset, not just the output, so a reset can never
    // release a stale acknowledge a few cycles later.
    generate
        if (SETTLE == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) stage <= '0;
                else     stage <= d;
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (rst) stage <= '0;
                else     stage <= {stage[SETTLE-2:0], d};
            end
        end
    endgenerate

    assign q = stage[SETTLE-1];

endmodule

// File: rtl/clk_branch_sequencer.sv
// Clock-branch enable sequencer: toggles one ICG enable at a time in round-robin
// order, then holds off for STAGGER cycles to bound supply inrush.
module clk_branch_sequencer
    import clk_seq_pkg::*;
#(
    parameter int NBR     = NBR_DEF,
    parameter int STAGGER = STAGGER_DEF,
    parameter int SETTLE  = SETTLE_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NBR-1:0] req,
    output logic [NBR-1:0] en,
    output logic [NBR-1:0] ack,
    output logic           busy
);

    localparam int PTR_W = (NBR > 1)     ? $clog2(NBR)     : 1;
    localparam int CNT_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;

    seq_state_e         state, state_next;
    logic [PTR_W-1:0]   ptr, ptr_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [NBR-1:0]     en_next;
    logic [MAX_NBR-1:0] mismatch;
    int                 idx;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            en    <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            en    <= en_next;
            ptr   <= ptr_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        en_next    = en;
        ptr_next   = ptr;
        cnt_next   = cnt;
        idx        = 0;
        mismatch   = MAX_NBR'(req ^ en);

        unique case (state)
            IDLE: begin
                if (mismatch != '0) begin
                    idx        = rr_first(mismatch, NBR, int'(ptr));
                    en_next    = en ^ (NBR'(1) << idx);
                    ptr_next   = PTR_W'((idx + 1) % NBR);
                    cnt_next   = CNT_W'(STAGGER - 1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // Requests are not looked at here; only the next IDLE sample counts.
                if (cnt == '0) state_next = IDLE;
                else           cnt_next   = cnt - 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == WAIT) | (|(req ^ en));

    generate
        for (genvar i = 0; i < NBR; i++) begin : g_ack
            clk_seq_dly #(.SETTLE(SETTLE)) u_dly (
                .clk (clk),
                .rst (rst),
                .d   (en[i]),
                .q   (ack[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_branch_sequencer.sv
// Scoreboard bench for clk_branch_sequencer: a cycle-level reference model pushes
// expected outputs, a negedge monitor pops and compares them.
module tb_clk_branch_sequencer;

    localparam int NBR     = 4;
    localparam int STAGGER = 8;
    localparam int SETTLE  = 2;

    logic           clk;
    logic           rst;
    logic [NBR-1:0] req;
    logic [NBR-1:0] en;
    logic [NBR-1:0] ack;
    logic           busy;

    clk_branch_sequencer #(
        .NBR     (NBR),
        .STAGGER (STAGGER),
        .SETTLE  (SETTLE)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .en   (en),
        .ack  (ack),
        .busy (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [NBR-1:0] en;
        logic [NBR-1:0] ack;
        logic           busy;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the enables change only when at least STAGGER+1 edges
    // have passed since the previous change; ack is the enable of SETTLE cycles ago.
    logic [NBR-1:0] m_en;
    int             m_ptr;
    int             edge_no = 0;
    int             last_change = -1000;
    logic [NBR-1:0] hist[$];

    task automatic model_step();
        logic [NBR-1:0] mism;
        bit             found;
        int             b;
        edge_no++;
        if (rst) begin
            m_en        = '0;
            m_ptr       = 0;
            last_change = -1000;
            hist.delete();
            for (int k = 0; k <= SETTLE; k++) hist.push_front('0);
        end else begin
            mism = req ^ m_en;
            if ((edge_no - last_change > STAGGER) && (mism != '0)) begin
                found = 0;
                for (int k = 0; k < NBR; k++) begin
                    b = (m_ptr + k) % NBR;
                    if (!found && mism[b]) begin
                        found       = 1;
                        m_en[b]     = ~m_en[b];
                        m_ptr       = (b + 1) % NBR;
                        last_change = edge_no;
                    end
                end
            end
            hist.push_front(m_en);
            void'(hist.pop_back());
        end
    endtask

    task automatic cycle(input logic [NBR-1:0] r, input logic rs);
        exp_t e;
        bit   waiting;
        @(posedge clk);
        model_step();
        #1;
        req = r;
        rst = rs;
        waiting = (edge_no + 1 <= last_change + STAGGER);
        e.en   = m_en;
        e.ack  = hist[SETTLE];
        e.busy = waiting || (r != m_en);
        sb.push_back(e);
    endtask

    task automatic hold(input logic [NBR-1:0] r, input logic rs, input int n);
        for (int k = 0; k < n; k++) cycle(r, rs);
    endtask

    // Monitor: scoreboard comparison plus independent one-bit / spacing checks.
    logic [NBR-1:0] prev_en = '0;
    logic           rst_last = 1'b1;
    int             neg_no = 0;
    int             last_en_change = -100;
    int             spacing;

    always @(negedge clk) begin
        exp_t e;
        logic applied_rst;
        neg_no++;
        applied_rst = rst_last;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("en",   32'(en),   32'(e.en));
            check("ack",  32'(ack),  32'(e.ack));
            check("busy", 32'(busy), 32'(e.busy));
        end
        if (applied_rst) begin
            last_en_change = -100;
        end else if (en !== prev_en) begin
            check("en_one_bit", 32'($countones(en ^ prev_en)), 32'd1);
            spacing = neg_no - last_en_change;
            check("en_spacing", 32'((spacing < STAGGER + 1) ? spacing : STAGGER + 1),
                  32'(STAGGER + 1));
            last_en_change = neg_no;
        end
        prev_en  = en;
        rst_last = rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NBR-1:0] r;
        rst = 1'b1;
        req = 4'b1111;

        // Reset held with all requests up, then all-on and all-off sweeps.
        hold(4'b1111, 1'b1, 2);
        hold(4'b1111, 1'b0, 40);
        hold(4'b0000, 1'b0, 40);

        // Single branch on from a clean reset.
        hold(4'b0000, 1'b1, 1);
        hold(4'b0001, 1'b0, 12);

        // Round-robin: service branch 1 first, then mismatch on bits 0 and 3.
        hold(4'b0000, 1'b1, 1);
        hold(4'b0010, 1'b0, 12);
        hold(4'b1011, 1'b0, 25);

        // Withdraw branch 1 before it is serviced.
        hold(4'b0000, 1'b1, 1);
        hold(4'b0011, 1'b0, 5);
        hold(4'b0001, 1'b0, 12);

        // Reset pulse in the middle of a WAIT window, then re-sequence.
        hold(4'b0000, 1'b1, 1);
        hold(4'b0111, 1'b0, 23);
        hold(4'b0111, 1'b1, 1);
        hold(4'b0111, 1'b0, 30);

        // Random request flips with occasional reset pulses.
        for (int n = 0; n < 3000; n++) begin
            r = req;
            if ($urandom_range(0, 5) == 0) r[$urandom_range(0, NBR - 1)] ^= 1'b1;
            cycle(r, ($urandom_range(0, 299) == 0));
        end

        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
